// File: rtl/ringbuf_stereo.sv
// ringbuf_stereo: stereo sample ring buffer with per-channel circular regions in one shared memory.
// Define RINGBUF_PREFILL_EN to add the per-channel FILL/RUN prefill state machine.
module ringbuf_stereo #(
  parameter int LOG2DEPTH = 5,
  parameter int DATA_W    = 24
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [1:0]                 push_i,
  input  logic signed [DATA_W-1:0]   data_i,
  input  logic [1:0]                 pop_i,
  input  logic                       clear_i,
  output logic signed [DATA_W-1:0]   data_o,
  output logic [1:0]                 ack_o,
  output logic [2*(LOG2DEPTH+1)-1:0] level_o,
  output logic [1:0]                 underrun_o,
  output logic [1:0]                 overflow_o
);
  localparam int PW    = LOG2DEPTH + 1;
  localparam int DEPTH = 1 << LOG2DEPTH;
  localparam logic [PW-1:0] FULL_LVL = PW'(DEPTH);

  logic [1:0][PW-1:0]       wptr_q, rptr_q, wptr_d, rptr_d, level;
  logic [1:0]               empty, full, run;
  logic                     push_any, push_ch, push_ok;
  logic                     pop_any, pop_ch, pop_take, pop_under;
  logic [1:0]               ovf_set, unr_set, ack_d;
  logic [PW-1:0]            wr_addr, rd_addr;
  logic signed [DATA_W-1:0] mem [2*DEPTH];
  logic signed [DATA_W-1:0] rd_data_p1;
  logic [1:0]               ack_p1;
  logic                     vld_p1;
  logic [1:0]               ovf_q, unr_q;

  always_comb begin
    for (int c = 0; c < 2; c++) begin
      level[c] = wptr_q[c] - rptr_q[c];
      empty[c] = (level[c] == '0);
      full[c]  = (level[c] == FULL_LVL);
    end
  end

  // Stage p0: decode requests against the pre-cycle empty/full state; L wins when both bits are set
  always_comb begin
    push_any  = |push_i;
    push_ch   = ~push_i[0];
    pop_any   = |pop_i;
    pop_ch    = ~pop_i[0];
    pop_take  = pop_any && run[pop_ch] && !empty[pop_ch];
    pop_under = pop_any && run[pop_ch] && empty[pop_ch];
    push_ok   = push_any && (!full[push_ch] || (pop_take && (pop_ch == push_ch)));
    wr_addr   = {push_ch, wptr_q[push_ch][LOG2DEPTH-1:0]};
    rd_addr   = {pop_ch, rptr_q[pop_ch][LOG2DEPTH-1:0]};
    ovf_set   = '0;
    unr_set   = '0;
    ack_d     = '0;
    if (push_any && !push_ok) ovf_set[push_ch] = 1'b1;
    if (&push_i)              ovf_set[1]       = 1'b1;
    if (pop_under)            unr_set[pop_ch]  = 1'b1;
    if (pop_any)              ack_d[pop_ch]    = 1'b1;
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    if (push_ok)  wptr_d[push_ch] = wptr_q[push_ch] + 1'b1;
    if (pop_take) rptr_d[pop_ch]  = rptr_q[pop_ch] + 1'b1;
  end

  // Stage p1: registered read; a full-channel push and pop share an address, the read sees the old word
  always_ff @(posedge clk) begin
    if (push_ok)  mem[wr_addr] <= data_i;
    if (pop_take) rd_data_p1   <= mem[rd_addr];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wptr_q <= '0;
      rptr_q <= '0;
      ack_p1 <= '0;
      vld_p1 <= 1'b0;
      ovf_q  <= '0;
      unr_q  <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      ack_p1 <= ack_d;
      vld_p1 <= pop_take;
      ovf_q  <= (ovf_q & {2{~clear_i}}) | ovf_set;
      unr_q  <= (unr_q & {2{~clear_i}}) | unr_set;
    end
  end

  assign ack_o      = ack_p1;
  assign data_o     = vld_p1 ? rd_data_p1 : '0;
  assign level_o    = {level[1], level[0]};
  assign overflow_o = ovf_q;
  assign underrun_o = unr_q;

`ifdef RINGBUF_PREFILL_EN
  localparam logic [PW-1:0] HALF_LVL = PW'(DEPTH / 2);

  typedef enum logic {FILL = 1'b0, RUN = 1'b1} pf_state_e;

  pf_state_e          state_q [2];
  pf_state_e          state_d [2];
  logic [1:0][PW-1:0] level_nxt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q[0] <= FILL;
      state_q[1] <= FILL;
    end else begin
      state_q[0] <= state_d[0];
      state_q[1] <= state_d[1];
    end
  end

  // Leave FILL on the edge where the level reaches half depth, so the very next pop is served
  always_comb begin
    for (int c = 0; c < 2; c++) begin
      level_nxt[c] = wptr_d[c] - rptr_d[c];
      state_d[c]   = state_q[c];
      case (state_q[c])
        FILL:    if (level_nxt[c] >= HALF_LVL) state_d[c] = RUN;
        RUN:     if (unr_set[c])               state_d[c] = FILL;
        default: state_d[c] = FILL;
      endcase
    end
  end

  always_comb begin
    for (int c = 0; c < 2; c++) begin
      run[c] = (state_q[c] == RUN);
    end
  end
`else
  assign run = 2'b11;
`endif

endmodule

// File: tb/tb_ringbuf_stereo.sv
// Directed self-checking bench for ringbuf_stereo (default build, or prefill build with RINGBUF_PREFILL_EN).
module tb_ringbuf_stereo;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [1:0]  push_i = '0;
  logic [23:0] data_i = '0;
  logic [1:0]  pop_i = '0;
  logic        clear_i = 1'b0;
  logic [23:0] data_o;
  logic [1:0]  ack_o;
  logic [11:0] level_o;
  logic [1:0]  underrun_o;
  logic [1:0]  overflow_o;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  ringbuf_stereo #(.LOG2DEPTH(5), .DATA_W(24)) dut (
    .clk(clk), .rst(rst), .push_i(push_i), .data_i(data_i), .pop_i(pop_i),
    .clear_i(clear_i), .data_o(data_o), .ack_o(ack_o), .level_o(level_o),
    .underrun_o(underrun_o), .overflow_o(overflow_o)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input logic [1:0] push, input logic [23:0] d, input logic [1:0] pop, input logic clr);
    push_i = push; data_i = d; pop_i = pop; clear_i = clr;
    @(posedge clk); #1;
    push_i = '0; data_i = '0; pop_i = '0; clear_i = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: observed=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    #3;
    chk("rst_level", 32'(level_o), 32'h0);
    chk("rst_ack", 32'(ack_o), 32'h0);
    chk("rst_data", 32'(data_o), 32'h0);
    chk("rst_unr", 32'(underrun_o), 32'h0);
    chk("rst_ovf", 32'(overflow_o), 32'h0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    cyc(2'b00, 24'h0, 2'b00, 1'b0);

`ifdef RINGBUF_PREFILL_EN
    for (int i = 1; i <= 15; i++) cyc(2'b01, 24'(i), 2'b00, 1'b0);
    chk("pf_lvl15", 32'(level_o[5:0]), 32'd15);
    cyc(2'b00, 24'h0, 2'b01, 1'b0);
    chk("pf_fill_ack", 32'(ack_o), 32'h1);
    chk("pf_fill_data", 32'(data_o), 32'h0);
    chk("pf_fill_lvl", 32'(level_o[5:0]), 32'd15);
    chk("pf_fill_unr", 32'(underrun_o), 32'h0);
    cyc(2'b01, 24'd16, 2'b00, 1'b0);
    cyc(2'b00, 24'h0, 2'b01, 1'b0);
    chk("pf_run_ack", 32'(ack_o), 32'h1);
    chk("pf_run_data", 32'(data_o), 32'h1);
    chk("pf_run_lvl", 32'(level_o[5:0]), 32'd15);
    for (int i = 2; i <= 16; i++) begin
      cyc(2'b00, 24'h0, 2'b01, 1'b0);
      chk("pf_drain", 32'(data_o), 32'(i));
    end
    chk("pf_drain_lvl", 32'(level_o[5:0]), 32'd0);
    cyc(2'b00, 24'h0, 2'b01, 1'b0);
    chk("pf_unr_ack", 32'(ack_o), 32'h1);
    chk("pf_unr_data", 32'(data_o), 32'h0);
    chk("pf_unr_flag", 32'(underrun_o), 32'h1);
    cyc(2'b00, 24'h0, 2'b00, 1'b1);
    chk("pf_clr", 32'(underrun_o), 32'h0);
    cyc(2'b01, 24'h5, 2'b00, 1'b0);
    cyc(2'b00, 24'h0, 2'b01, 1'b0);
    chk("pf_refill_data", 32'(data_o), 32'h0);
    chk("pf_refill_lvl", 32'(level_o[5:0]), 32'd1);
    chk("pf_refill_unr", 32'(underrun_o), 32'h0);
`else
    for (int i = 1; i <= 3; i++) cyc(2'b01, 24'(i), 2'b00, 1'b0);
    chk("lvl3", 32'(level_o[5:0]), 32'd3);
    for (int i = 1; i <= 3; i++) begin
      cyc(2'b00, 24'h0, 2'b01, 1'b0);
      chk("pop_ack", 32'(ack_o), 32'h1);
      chk("pop_data", 32'(data_o), 32'(i));
      chk("pop_lvl", 32'(level_o[5:0]), 32'(3 - i));
    end
    cyc(2'b00, 24'h0, 2'b00, 1'b0);
    chk("ack_pulse", 32'(ack_o), 32'h0);
    chk("idle_data", 32'(data_o), 32'h0);

    cyc(2'b00, 24'h0, 2'b10, 1'b0);
    chk("unr_ack", 32'(ack_o), 32'h2);
    chk("unr_data", 32'(data_o), 32'h0);
    chk("unr_flag", 32'(underrun_o), 32'h2);
    cyc(2'b00, 24'h0, 2'b10, 1'b1);
    chk("unr_set_wins", 32'(underrun_o), 32'h2);
    cyc(2'b00, 24'h0, 2'b00, 1'b1);
    chk("unr_clr", 32'(underrun_o), 32'h0);

    for (int i = 1; i <= 33; i++) cyc(2'b01, 24'(i), 2'b00, 1'b0);
    chk("full_lvl", 32'(level_o[5:0]), 32'd32);
    chk("full_ovf", 32'(overflow_o), 32'h1);
    for (int i = 1; i <= 32; i++) begin
      cyc(2'b00, 24'h0, 2'b01, 1'b0);
      chk("drain_data", 32'(data_o), 32'(i));
    end
    chk("drain_lvl", 32'(level_o[5:0]), 32'd0);
    cyc(2'b00, 24'h0, 2'b00, 1'b1);
    chk("ovf_clr", 32'(overflow_o), 32'h0);

    for (int i = 0; i < 32; i++) cyc(2'b01, 24'h100 + 24'(i), 2'b00, 1'b0);
    cyc(2'b01, 24'hABCDEF, 2'b01, 1'b0);
    chk("pp_full_ack", 32'(ack_o), 32'h1);
    chk("pp_full_data", 32'(data_o), 32'h100);
    chk("pp_full_lvl", 32'(level_o[5:0]), 32'd32);
    chk("pp_full_ovf", 32'(overflow_o), 32'h0);
    for (int i = 1; i < 32; i++) begin
      cyc(2'b00, 24'h0, 2'b01, 1'b0);
      chk("pp_drain", 32'(data_o), 32'h100 + 32'(i));
    end
    cyc(2'b00, 24'h0, 2'b01, 1'b0);
    chk("pp_last", 32'(data_o), 32'hABCDEF);
    chk("pp_lvl0", 32'(level_o[5:0]), 32'd0);

    cyc(2'b01, 24'h55, 2'b00, 1'b0);
    cyc(2'b10, 24'h66, 2'b00, 1'b0);
    cyc(2'b00, 24'h0, 2'b11, 1'b0);
    chk("pop11_ack", 32'(ack_o), 32'h1);
    chk("pop11_data", 32'(data_o), 32'h55);
    chk("pop11_lvl_r", 32'(level_o[11:6]), 32'd1);
    chk("pop11_lvl_l", 32'(level_o[5:0]), 32'd0);
    cyc(2'b00, 24'h0, 2'b10, 1'b0);
    chk("pop_r_ack", 32'(ack_o), 32'h2);
    chk("pop_r_data", 32'(data_o), 32'h66);
    chk("pop_r_unr", 32'(underrun_o), 32'h0);

    cyc(2'b11, 24'h77, 2'b00, 1'b0);
    chk("push11_lvl", 32'(level_o), 32'h001);
    chk("push11_ovf", 32'(overflow_o), 32'h2);
    cyc(2'b00, 24'h0, 2'b01, 1'b0);
    chk("push11_data", 32'(data_o), 32'h77);
    cyc(2'b00, 24'h0, 2'b00, 1'b1);

    cyc(2'b01, 24'h99, 2'b01, 1'b0);
    chk("pp_empty_ack", 32'(ack_o), 32'h1);
    chk("pp_empty_data", 32'(data_o), 32'h0);
    chk("pp_empty_unr", 32'(underrun_o), 32'h1);
    chk("pp_empty_lvl", 32'(level_o[5:0]), 32'd1);
    cyc(2'b00, 24'h0, 2'b01, 1'b0);
    chk("pp_empty_pop", 32'(data_o), 32'h99);

    cyc(2'b01, 24'h42, 2'b00, 1'b0);
    cyc(2'b00, 24'h0, 2'b01, 1'b0);
    chk("vis_next", 32'(data_o), 32'h42);
    cyc(2'b01, 24'h43, 2'b00, 1'b0);
    pop_i = 2'b01;
    #2 rst = 1'b0;
    @(posedge clk); #1;
    pop_i = 2'b00;
    chk("mid_rst_ack", 32'(ack_o), 32'h0);
    chk("mid_rst_lvl", 32'(level_o), 32'h0);
    chk("mid_rst_unr", 32'(underrun_o), 32'h0);
    rst = 1'b1;
    cyc(2'b00, 24'h0, 2'b00, 1'b0);
    chk("post_rst_ack", 32'(ack_o), 32'h0);
    chk("post_rst_data", 32'(data_o), 32'h0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/ringbuf_stereo.md
# ringbuf_stereo

Stereo 24-bit sample ring buffer that sits directly upstream of the resample pipeline and absorbs the rate mismatch between the audio receiver (push side) and the pipeline's pop/ack interface (pop side). Each channel has its own circular region in one shared memory. Pops are always acknowledged one cycle later, so the downstream resampler never stalls. Underrun and overflow are counted as sticky flags for host readout.

## Interface
- LOG2DEPTH, 5: per-channel depth is 2^LOG2DEPTH samples (32).
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  asynchronous, active-low reset.
- push_i  in  2  one-hot write strobe, bit0 = L, bit1 = R.
- data_i  in  24  sample written on push_i.
- pop_i  in  2  one-hot read request from resample pipeline, bit0 = L, bit1 = R.
- data_o  out  24  sample returned; valid only while ack_o != 0, else 0.
- ack_o  out  2  one-hot read acknowledge, one cycle after pop_i.
- level_o  out  2*(LOG2DEPTH+1)  fill level, [LOG2DEPTH:0] = L, upper half = R.
- underrun_o  out  2  sticky per-channel underrun flag.
- overflow_o  out  2  sticky per-channel overflow flag.
- clear_i  in  1  synchronous clear of underrun_o/overflow_o.

## Operation
- Per channel: write pointer, read pointer, each LOG2DEPTH+1 bits; level = wptr - rptr (modulo 2^(LOG2DEPTH+1)); empty when level == 0, full when level == 2^LOG2DEPTH.
- Memory address = {ch, ptr[LOG2DEPTH-1:0]}; 2*2^LOG2DEPTH x 24 array, one write port, one registered read port.
- push_i == 2'b11: L written, R dropped, overflow_o[1] set. Same rule for pop_i == 2'b11: L served, R gets no ack.
- Push to full channel: sample dropped, pointer unchanged, overflow_o[ch] set.
- Pop from non-empty channel: read memory at rptr, rptr++, ack_o[ch]=1 next cycle with that sample.
- Pop from empty channel: ack_o[ch]=1 next cycle with data_o = 0, rptr unchanged, underrun_o[ch] set.
- Empty/full are evaluated on the pre-cycle state: a simultaneous push and pop on an empty channel is an underrun (push still stored); on a full channel both succeed (pop frees the slot, push stored, no overflow).
- Pointer wrap: natural binary wrap of LOG2DEPTH+1-bit pointers; no special case.
- clear_i clears the flags; a flag event in the same cycle as clear_i wins (flag stays set).

## Timing
- Reset (rst low, async): all pointers 0, level_o 0, ack_o 0, data_o 0, underrun_o 0, overflow_o 0. Memory contents are not reset.
- Pop latency: exactly 1 cycle pop_i -> ack_o/data_o; ack_o is a 1-cycle pulse.
- Back-to-back pops every cycle are supported, including alternating L/R.
- Push-to-pop visibility: a sample pushed in cycle N is readable by a pop in cycle N+1.
- level_o is registered and reflects all pushes/pops up to the previous edge.
- Reset asserted mid-operation: a pending ack is dropped; the first ack after release requires a new pop.

## Configuration
- RINGBUF_PREFILL_EN defined: per-channel prefill state machine, states FILL and RUN. Reset and every underrun enter FILL. In FILL, pops are acked with data_o = 0 without consuming and without setting underrun_o; the channel moves to RUN when level reaches 2^(LOG2DEPTH-1) (16). In RUN, behaviour is as in Operation; an underrun sets the flag and returns to FILL.
- Not defined: no prefill; channels are always in RUN behaviour.

## Test plan
- Reset, push L samples 0x000001..0x000003, pop L x3 -> ack_o=2'b01 one cycle after each pop, data_o 0x000001, 0x000002, 0x000003; level_o L goes 3 -> 0.
- Pop R on empty buffer -> ack_o=2'b10 next cycle, data_o=0, underrun_o=2'b10; clear_i -> flag 0.
- Push 33 L samples without pops -> 33rd dropped, overflow_o[0]=1, level L=32; pop 32 -> samples 1..32 in order, pointers wrap cleanly.
- Full L channel, push and pop L in same cycle -> pop returns oldest, push stored, level stays 32, no overflow.
- pop_i=2'b11 with both channels non-empty -> only ack_o=2'b01; R level unchanged.
- With RINGBUF_PREFILL_EN: push 15 L, pop L -> data_o 0, level 15, no underrun; push 1 more then pop -> first pushed sample returned.
